// File: rtl/aib_hrdrst_pkg.sv
// Shared definitions for the AIB hard-reset sequencers: slave FSM state
// encoding, counter width and slave status bit positions.
package aib_hrdrst_pkg;

  localparam int unsigned HRDRST_CNT_W = 16;

  // Bit positions inside the packed c_sl_* status vector
  localparam int unsigned SL_OSC = 0;
  localparam int unsigned SL_DLL = 1;
  localparam int unsigned SL_RXX = 2;
  localparam int unsigned SL_DCD = 3;
  localparam int unsigned SL_TXX = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OSC,
    ST_DLL,
    ST_RXX,
    ST_DCD,
    ST_TXX,
    ST_ALIGN,
    ST_DONE
  } hrdrst_sl_state_e;

endpackage

// File: rtl/aib_hrdrst_cnt.sv
// Loadable down-counter with zero flag; holds at zero until reloaded.
module aib_hrdrst_cnt
  import aib_hrdrst_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [HRDRST_CNT_W-1:0] load_val,
  output logic                    zero
);

  logic [HRDRST_CNT_W-1:0] count;

  // Load has priority; otherwise count down and stop at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/aib_hrdrst_sl.sv
// Slave-side AIB hard-reset sequencer on the aux clock.
// Optional watchdog: define AIB_HRDRST_SL_TIMEOUT_EN.
module aib_hrdrst_sl
  import aib_hrdrst_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic i_aux_clk,
  input  logic i_rst_n,
  input  logic c_ms_osc_transfer_en,
  input  logic c_ms_tx_dcd_cal_done,
  input  logic c_ms_tx_transfer_en,
  input  logic c_ms_rx_dll_lock,
  input  logic c_ms_rx_dcd_cal_done,
  input  logic c_ms_rx_transfer_en,
  input  logic c_ms_rx_align_done,
  input  logic i_rx_dll_lock,
  input  logic i_tx_dcd_cal_done,
  output logic o_rx_dll_en,
  output logic o_tx_dcd_cal_en,
  output logic c_sl_osc_transfer_en,
  output logic c_sl_rx_dll_lock,
  output logic c_sl_rx_transfer_en,
  output logic c_sl_tx_dcd_cal_done,
  output logic c_sl_tx_transfer_en,
  output logic o_hrdrst_done,
  output logic o_timeout
);

  localparam logic [HRDRST_CNT_W-1:0] SETTLE_LD = HRDRST_CNT_W'(SETTLE_CYCLES);

  hrdrst_sl_state_e state_q, state_d;
  logic       busy_q, busy_d;
  logic [4:0] sl_q, sl_d;
  logic       rx_dll_en_q, tx_dcd_cal_en_q, done_q;
  logic       settle_ld, settle_zero;
  logic       ms_ok, kill, wd_fire;
  logic       ms_rx_all;

  assign ms_rx_all = c_ms_rx_dll_lock & c_ms_rx_dcd_cal_done & c_ms_rx_transfer_en;

  aib_hrdrst_cnt u_settle (
    .clk      (i_aux_clk),
    .rst_n    (i_rst_n),
    .load     (settle_ld),
    .load_val (SETTLE_LD),
    .zero     (settle_zero)
  );

  // Master bits already consumed by the current state must stay high
  always_comb begin
    ms_ok = 1'b1;
    case (state_q)
      ST_OSC:           ms_ok = c_ms_osc_transfer_en;
      ST_DLL:           ms_ok = c_ms_osc_transfer_en & c_ms_tx_dcd_cal_done;
      ST_RXX, ST_DCD:   ms_ok = c_ms_osc_transfer_en & c_ms_tx_dcd_cal_done &
                                c_ms_tx_transfer_en;
      ST_TXX, ST_ALIGN: ms_ok = c_ms_osc_transfer_en & c_ms_tx_dcd_cal_done &
                                c_ms_tx_transfer_en & ms_rx_all;
      ST_DONE:          ms_ok = c_ms_osc_transfer_en & c_ms_tx_dcd_cal_done &
                                c_ms_tx_transfer_en & ms_rx_all & c_ms_rx_align_done;
      default:          ms_ok = 1'b1;
    endcase
  end

  assign kill = ~ms_ok | wd_fire;

  // Next-state: the master gate for a state is sampled at the tail of the
  // previous one (after its c_sl_* bit is up), so entry and settle-load coincide.
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    sl_d      = sl_q;
    settle_ld = 1'b0;
    if (kill) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      sl_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: if (c_ms_osc_transfer_en) begin
          state_d = ST_OSC; settle_ld = 1'b1; busy_d = 1'b1;
        end
        ST_OSC: if (!sl_q[SL_OSC]) begin
          if (busy_q && settle_zero) begin sl_d[SL_OSC] = 1'b1; busy_d = 1'b0; end
        end else if (c_ms_tx_dcd_cal_done) begin
          state_d = ST_DLL;
        end
        ST_DLL: if (!sl_q[SL_DLL]) begin
          if (busy_q) begin
            if (settle_zero) begin sl_d[SL_DLL] = 1'b1; busy_d = 1'b0; end
          end else if (i_rx_dll_lock) begin
            settle_ld = 1'b1; busy_d = 1'b1;
          end
        end else if (c_ms_tx_transfer_en) begin
          state_d = ST_RXX; settle_ld = 1'b1; busy_d = 1'b1;
        end
        ST_RXX: if (busy_q && settle_zero) begin
          sl_d[SL_RXX] = 1'b1; busy_d = 1'b0; state_d = ST_DCD;
        end
        ST_DCD: if (!sl_q[SL_DCD]) begin
          if (busy_q) begin
            if (settle_zero) begin sl_d[SL_DCD] = 1'b1; busy_d = 1'b0; end
          end else if (i_tx_dcd_cal_done) begin
            settle_ld = 1'b1; busy_d = 1'b1;
          end
        end else if (ms_rx_all) begin
          state_d = ST_TXX; settle_ld = 1'b1; busy_d = 1'b1;
        end
        ST_TXX: if (busy_q && settle_zero) begin
          sl_d[SL_TXX] = 1'b1; busy_d = 1'b0; state_d = ST_ALIGN;
        end
        ST_ALIGN: if (c_ms_rx_align_done) state_d = ST_DONE;
        default: ;
      endcase
    end
  end

  // State and registered outputs; enables/done follow the state one cycle late
  always_ff @(posedge i_aux_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q         <= ST_IDLE;
      busy_q          <= 1'b0;
      sl_q            <= '0;
      rx_dll_en_q     <= 1'b0;
      tx_dcd_cal_en_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      busy_q          <= busy_d;
      sl_q            <= sl_d;
      rx_dll_en_q     <= ~kill & (state_q >= ST_DLL);
      tx_dcd_cal_en_q <= ~kill & (state_q >= ST_DCD);
      done_q          <= ~kill & (state_q == ST_DONE);
    end
  end

`ifdef AIB_HRDRST_SL_TIMEOUT_EN
  localparam logic [HRDRST_CNT_W-1:0] WD_LD =
    HRDRST_CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  logic wd_ld, wd_zero, timeout_q;

  // Reload on any state change and while parked in IDLE/DONE
  assign wd_ld   = (state_d != state_q) | (state_q == ST_IDLE) | (state_q == ST_DONE);
  assign wd_fire = wd_zero & (state_q != ST_IDLE) & (state_q != ST_DONE);

  aib_hrdrst_cnt u_wdog (
    .clk      (i_aux_clk),
    .rst_n    (i_rst_n),
    .load     (wd_ld),
    .load_val (WD_LD),
    .zero     (wd_zero)
  );

  // One-cycle timeout pulse
  always_ff @(posedge i_aux_clk or negedge i_rst_n) begin
    if (!i_rst_n) timeout_q <= 1'b0;
    else          timeout_q <= wd_fire;
  end

  assign o_timeout = timeout_q;
`else
  assign wd_fire   = 1'b0;
  assign o_timeout = 1'b0;
`endif

  assign o_rx_dll_en          = rx_dll_en_q;
  assign o_tx_dcd_cal_en      = tx_dcd_cal_en_q;
  assign o_hrdrst_done        = done_q;
  assign c_sl_osc_transfer_en = sl_q[SL_OSC];
  assign c_sl_rx_dll_lock     = sl_q[SL_DLL];
  assign c_sl_rx_transfer_en  = sl_q[SL_RXX];
  assign c_sl_tx_dcd_cal_done = sl_q[SL_DCD];
  assign c_sl_tx_transfer_en  = sl_q[SL_TXX];

endmodule
